key_event_decoder: RTL and testbench

Per-key press classifier placed directly downstream of the three-key debounce stage. It takes the debounced, active-low, clock-synchronous key levels and turns each key's press pattern into one-cycle event pulses: short press, long press or double click. The pulses drive the mode and LED control logic that follows. The three key channels are identical and fully independent.

---
 rtl/key_event_decoder.sv | 122 ++++++++++++
 tb/tb_key_event_decoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - three-channel key press classifier: short, long and double-click pulses
module key_event_decoder #(
  parameter int LONG_CYC = 50_000_000,
  parameter int DBL_CYC  = 15_000_000,
  parameter int CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_n,
  output logic [2:0] short_pulse,
  output logic [2:0] long_pulse,
  output logic [2:0] dbl_pulse
);

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, HELD} state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);

  genvar i;
  generate
    for (i = 0; i < 3; i++) begin : g_ch
      state_t           state, state_nx;
      logic [CNT_W-1:0] cnt, cnt_nx;
      logic             s;
      logic             sp, lp, dp;
      logic             sp_nx, lp_nx, dp_nx;
      logic             press, rel;

      // s resets to 0 so a key held through reset never counts as a fresh press
      assign press = s & ~key_n[i];
      assign rel   = key_n[i];

      assign short_pulse[i] = sp;
      assign long_pulse[i]  = lp;
      assign dbl_pulse[i]   = dp;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s     <= 1'b0;
          state <= IDLE;
          cnt   <= '0;
          sp    <= 1'b0;
          lp    <= 1'b0;
          dp    <= 1'b0;
        end else begin
          s     <= key_n[i];
          state <= state_nx;
          cnt   <= cnt_nx;
          sp    <= sp_nx;
          lp    <= lp_nx;
          dp    <= dp_nx;
        end
      end

      always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sp_nx    = 1'b0;
        lp_nx    = 1'b0;
        dp_nx    = 1'b0;
        case (state)
          IDLE: begin
            if (press) begin
              state_nx = PRESS1;
              cnt_nx   = '0;
            end
          end
          PRESS1: begin
            if (rel) begin
              state_nx = WAIT2;
              cnt_nx   = '0;
            end else if (cnt == LONG_LAST) begin
              state_nx = HELD;
              cnt_nx   = '0;
              lp_nx    = 1'b1;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
          WAIT2: begin
            // a second press on the timeout edge still wins
            if (!key_n[i]) begin
              state_nx = PRESS2;
              cnt_nx   = '0;
            end else if (cnt == DBL_LAST) begin
              state_nx = IDLE;
              cnt_nx   = '0;
              sp_nx    = 1'b1;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
          PRESS2: begin
            if (rel) begin
              state_nx = IDLE;
              cnt_nx   = '0;
              dp_nx    = 1'b1;
            end else if (cnt == LONG_LAST) begin
              state_nx = HELD;
              cnt_nx   = '0;
              dp_nx    = 1'b1;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
          HELD: begin
            if (rel) begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end
          end
          default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        endcase
      end
    end
  endgenerate

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - randomized self-checking bench for key_event_decoder
module tb_key_event_decoder;

  localparam int LONG = 20;
  localparam int DBL  = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_n = 3'b111;
  logic [2:0] short_pulse, long_pulse, dbl_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] kt[$];
  logic [8:0] obs[$];
  logic [8:0] expv[$];

  key_event_decoder #(.LONG_CYC(LONG), .DBL_CYC(DBL), .CNT_W(26)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n),
    .short_pulse(short_pulse), .long_pulse(long_pulse), .dbl_pulse(dbl_pulse)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [2:0] v, input int cycles);
    for (int j = 0; j < cycles; j++) kt.push_back(v);
  endtask

  function automatic bit kv(input int t, input int ch);
    logic [2:0] tmp;
    if (t < 0) return 1'b0;
    tmp = kt[t];
    return tmp[ch];
  endfunction

  // Event model: walk the key trace run by run and place each event on its decisive edge.
  task automatic compute_expected();
    int n, x, p, r, q, r2, e;
    n = kt.size();
    expv.delete();
    for (int t = 0; t < n; t++) expv.push_back(9'd0);
    for (int ch = 0; ch < 3; ch++) begin
      x = -1;
      forever begin
        p = -1;
        for (int t = x + 1; t < n; t++)
          if (kv(t - 1, ch) && !kv(t, ch)) begin p = t; break; end
        if (p < 0) break;
        r = n;
        for (int t = p + 1; t < n; t++) if (kv(t, ch)) begin r = t; break; end
        if (r - p > LONG) begin
          if (p + LONG < n) expv[p + LONG] = expv[p + LONG] | (9'd1 << (3 + ch));
          x = r;
        end else begin
          if (r >= n) break;
          q = -1;
          for (int t = r + 1; t <= r + DBL && t < n; t++)
            if (!kv(t, ch)) begin q = t; break; end
          if (q < 0) begin
            if (r + DBL < n) expv[r + DBL] = expv[r + DBL] | (9'd1 << ch);
            x = r + DBL;
          end else begin
            r2 = n;
            for (int t = q + 1; t < n; t++) if (kv(t, ch)) begin r2 = t; break; end
            e = (r2 < q + LONG) ? r2 : q + LONG;
            if (e < n) expv[e] = expv[e] | (9'd1 << (6 + ch));
            x = r2;
          end
        end
        if (x >= n) break;
      end
    end
  endtask

  task automatic do_reset(input logic [2:0] k);
    rst_n = 1'b0;
    key_n = k;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic play(input logic [2:0] rst_key);
    do_reset(rst_key);
    obs.delete();
    for (int t = 0; t < kt.size(); t++) begin
      key_n = kt[t];
      @(posedge clk);
      #1 obs.push_back({dbl_pulse, long_pulse, short_pulse});
    end
    compute_expected();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_n = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (short_pulse !== 3'b000) begin n_fail++; $display("FAIL reset_short got %b want 000", short_pulse); end
    n_checks++;
    if (long_pulse !== 3'b000) begin n_fail++; $display("FAIL reset_long got %b want 000", long_pulse); end
    n_checks++;
    if (dbl_pulse !== 3'b000) begin n_fail++; $display("FAIL reset_dbl got %b want 000", dbl_pulse); end
  endtask

  task automatic test_short();
    int cnt;
    kt.delete();
    add(3'b111, 2); add(3'b110, 5); add(3'b111, 15);
    play(3'b111);
    n_checks++;
    if (obs[17] !== 9'b000_000_001) begin n_fail++; $display("FAIL short_edge got %b want 000000001", obs[17]); end
    cnt = 0;
    foreach (obs[t]) if (obs[t] != 9'd0) cnt++;
    n_checks++;
    if (cnt != 1) begin n_fail++; $display("FAIL short_count got %0d want 1", cnt); end
    foreach (obs[t]) begin
      n_checks++;
      if (obs[t] !== expv[t]) begin n_fail++; $display("FAIL short_cyc%0d got %b want %b", t, obs[t], expv[t]); end
    end
  endtask

  task automatic test_long();
    int cnt;
    kt.delete();
    add(3'b111, 2); add(3'b101, 30); add(3'b111, 20);
    play(3'b111);
    n_checks++;
    if (obs[22] !== 9'b000_010_000) begin n_fail++; $display("FAIL long_edge got %b want 000010000", obs[22]); end
    cnt = 0;
    foreach (obs[t]) if (obs[t] != 9'd0) cnt++;
    n_checks++;
    if (cnt != 1) begin n_fail++; $display("FAIL long_count got %0d want 1", cnt); end
    foreach (obs[t]) begin
      n_checks++;
      if (obs[t] !== expv[t]) begin n_fail++; $display("FAIL long_cyc%0d got %b want %b", t, obs[t], expv[t]); end
    end
  endtask

  task automatic test_double();
    kt.delete();
    add(3'b111, 2); add(3'b011, 3); add(3'b111, 4); add(3'b011, 3); add(3'b111, 20);
    play(3'b111);
    n_checks++;
    if (obs[12] !== 9'b100_000_000) begin n_fail++; $display("FAIL dbl_edge got %b want 100000000", obs[12]); end
    foreach (obs[t]) begin
      n_checks++;
      if (obs[t] !== expv[t]) begin n_fail++; $display("FAIL dbl_cyc%0d got %b want %b", t, obs[t], expv[t]); end
    end
    // second press lands on the 10th WAIT2 edge
    kt.delete();
    add(3'b111, 2); add(3'b011, 3); add(3'b111, 10); add(3'b011, 3); add(3'b111, 20);
    play(3'b111);
    n_checks++;
    if (obs[18] !== 9'b100_000_000) begin n_fail++; $display("FAIL dbl_boundary got %b want 100000000", obs[18]); end
    n_checks++;
    if (obs[15] !== 9'd0) begin n_fail++; $display("FAIL dbl_boundary_noshort got %b want 000000000", obs[15]); end
    foreach (obs[t]) begin
      n_checks++;
      if (obs[t] !== expv[t]) begin n_fail++; $display("FAIL dblb_cyc%0d got %b want %b", t, obs[t], expv[t]); end
    end
  endtask

  task automatic test_held_reset();
    int cnt;
    kt.delete();
    add(3'b110, 40); add(3'b111, 20); add(3'b110, 5); add(3'b111, 15);
    play(3'b110);
    cnt = 0;
    for (int t = 0; t < 60; t++) if (obs[t] != 9'd0) cnt++;
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("FAIL held_reset_quiet got %0d pulses want 0", cnt); end
    n_checks++;
    if (obs[75] !== 9'b000_000_001) begin n_fail++; $display("FAIL held_reset_short got %b want 000000001", obs[75]); end
    foreach (obs[t]) begin
      n_checks++;
      if (obs[t] !== expv[t]) begin n_fail++; $display("FAIL held_cyc%0d got %b want %b", t, obs[t], expv[t]); end
    end
  endtask

  task automatic test_parallel();
    kt.delete();
    add(3'b111, 2); add(3'b000, 5); add(3'b111, 15);
    play(3'b111);
    n_checks++;
    if (obs[17] !== 9'b000_000_111) begin n_fail++; $display("FAIL parallel_short got %b want 000000111", obs[17]); end
    foreach (obs[t]) begin
      n_checks++;
      if (obs[t] !== expv[t]) begin n_fail++; $display("FAIL par_cyc%0d got %b want %b", t, obs[t], expv[t]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(3'b111);
    key_n = 3'b111;
    repeat (2) @(posedge clk);
    #1 key_n = 3'b101;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if ({dbl_pulse, long_pulse, short_pulse} !== 9'd0) begin
        n_fail++; $display("FAIL mid_reset_out got %b want 000000000", {dbl_pulse, long_pulse, short_pulse});
      end
      @(posedge clk);
    end
    #1 rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (long_pulse !== 3'b000) begin n_fail++; $display("FAIL mid_reset_long c%0d got %b want 000", c, long_pulse); end
    end
    key_n = 3'b111;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({dbl_pulse, long_pulse, short_pulse} !== 9'd0) begin
        n_fail++; $display("FAIL mid_reset_release c%0d got %b want 000000000", c, {dbl_pulse, long_pulse, short_pulse});
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] v;
    int         run_left[3];
    logic       lvl[3];
    for (int it = 0; it < 6; it++) begin
      kt.delete();
      for (int ch = 0; ch < 3; ch++) begin
        lvl[ch] = 1'b1;
        run_left[ch] = $urandom_range(1, 30);
      end
      for (int t = 0; t < 250; t++) begin
        for (int ch = 0; ch < 3; ch++) begin
          v[ch] = lvl[ch];
          run_left[ch]--;
          if (run_left[ch] == 0) begin
            lvl[ch] = ~lvl[ch];
            run_left[ch] = (it < 3) ? $urandom_range(1, 14) : $urandom_range(1, 30);
          end
        end
        kt.push_back(v);
      end
      add(3'b111, 40);
      play(3'b111);
      foreach (obs[t]) begin
        n_checks++;
        if (obs[t] !== expv[t]) begin n_fail++; $display("FAIL rand%0d_cyc%0d got %b want %b", it, t, obs[t], expv[t]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_held_reset();
    test_parallel();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
